// File: rtl/conv_pkg.sv
// Shared definitions for the convolution path: default pixel width, Q16.16
// constants and the pixel/window payload types.
package conv_pkg;

  localparam int unsigned DATA_W_DFLT = 32;
  localparam int unsigned FRAC_BITS   = 16;
  localparam int unsigned WIN_TAPS    = 9;

  typedef logic [DATA_W_DFLT-1:0] pixel_t;
  typedef pixel_t [WIN_TAPS-1:0]  win_t;

  localparam pixel_t ONE = DATA_W_DFLT'(32'h0001_0000);

endpackage

// File: rtl/conv_line_buffer.sv
// Two-row line buffer for the 3x3 window generator.
// Ports:
//   i_clk    - clock
//   i_we     - write enable (one pixel accepted)
//   i_addr   - column address, shared by read and write
//   i_wdata  - incoming pixel, written into row tap 0
//   o_tap0_c - previous row at i_addr (combinational read)
//   o_tap1_c - row before that at i_addr (combinational read)
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = DATA_W_DFLT,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_tap0_c,
  output logic [DW-1:0] o_tap1_c
);

  // Contents are intentionally not reset; the row counter gates their use.
  logic [DW-1:0] r_mem0 [DEPTH];
  logic [DW-1:0] r_mem1 [DEPTH];

  assign o_tap0_c = r_mem0[i_addr];
  assign o_tap1_c = r_mem1[i_addr];

  // Read-before-write: tap 0 cascades into tap 1 at the same column.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem1[i_addr] <= r_mem0[i_addr];
      r_mem0[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator ("valid" convolution, no padding).
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   in_valid/in_ready       - raster pixel stream handshake
//   in_data, in_last        - pixel word and end-of-frame marker
//   out_valid/out_ready     - window handshake
//   out_w0..out_w8          - window, row-major, out_w8 = newest pixel
//   out_last                - final window of the frame
//   err_last                - sticky in_last position mismatch
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DFLT,
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_w0,
  output logic [DATA_W-1:0] out_w1,
  output logic [DATA_W-1:0] out_w2,
  output logic [DATA_W-1:0] out_w3,
  output logic [DATA_W-1:0] out_w4,
  output logic [DATA_W-1:0] out_w5,
  output logic [DATA_W-1:0] out_w6,
  output logic [DATA_W-1:0] out_w7,
  output logic [DATA_W-1:0] out_w8,
  output logic              out_last,
  output logic              err_last
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]         r_col;
  logic [ROW_W-1:0]         r_row;
  logic [8:0][DATA_W-1:0]   r_win;
  logic                     r_out_valid;
  logic                     r_out_last;
  logic                     r_err_last;

  logic                     w_accept;
  logic                     w_final;
  logic                     w_resync;
  logic                     w_emit;
  logic [DATA_W-1:0]        w_lb0;
  logic [DATA_W-1:0]        w_lb1;

  // Single output stage: accept whenever the window slot is free or draining.
  assign in_ready = !rst && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_final  = (r_row == ROW_MAX) && (r_col == COL_MAX);
  // Early in_last resynchronises the frame and suppresses that pixel's window.
  assign w_resync = in_last && !w_final;
  assign w_emit   = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2)) && !w_resync;

  conv_line_buffer #(
    .DEPTH (IMG_W),
    .DW    (DATA_W)
  ) u_line_buffer (
    .i_clk    (clk),
    .i_we     (w_accept),
    .i_addr   (r_col),
    .i_wdata  (in_data),
    .o_tap0_c (w_lb0),
    .o_tap1_c (w_lb1)
  );

  // Window shift, raster counters, output qualifiers and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_win       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_err_last  <= 1'b0;
    end else if (w_accept) begin
      r_win[0] <= r_win[1];
      r_win[1] <= r_win[2];
      r_win[2] <= w_lb1;
      r_win[3] <= r_win[4];
      r_win[4] <= r_win[5];
      r_win[5] <= w_lb0;
      r_win[6] <= r_win[7];
      r_win[7] <= r_win[8];
      r_win[8] <= in_data;

      if (w_resync) begin
        r_col      <= '0;
        r_row      <= '0;
        r_err_last <= 1'b1;
      end else if (w_final) begin
        r_col <= '0;
        r_row <= '0;
        if (!in_last) begin
          r_err_last <= 1'b1;
        end
      end else if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end

      r_out_valid <= w_emit;
      r_out_last  <= w_emit && w_final;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign err_last  = r_err_last;
  assign out_w0    = r_win[0];
  assign out_w1    = r_win[1];
  assign out_w2    = r_win[2];
  assign out_w3    = r_win[3];
  assign out_w4    = r_win[4];
  assign out_w5    = r_win[5];
  assign out_w6    = r_win[6];
  assign out_w7    = r_win[7];
  assign out_w8    = r_win[8];

endmodule
